// File: rtl/soc_ctrl_rst_seq.sv
// Per-domain reset/clock-enable sequencer: ordered boot, then optional software re-reset of single domains.
// Software re-reset path is built only when SOC_CTRL_RST_SEQ_SW_RST_EN is defined.
module soc_ctrl_rst_seq #(
  parameter int NUM_DOMAINS = 2,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                   ref_clk_i,
  input  logic                   glb_arst_ni,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] sw_rst_ack_o,
  output logic [NUM_DOMAINS-1:0] arst_no,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic                   done_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  // Counter is loaded with GAP_CYCLES-1 so that the transition edge is the last cycle of a phase.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_DOM = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [2:0] BOOT_HOLD    = 3'd0;
  localparam logic [2:0] BOOT_RST_REL = 3'd1;
  localparam logic [2:0] BOOT_CLK_ON  = 3'd2;
  localparam logic [2:0] RUN          = 3'd3;
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
  localparam logic [2:0] SW_CLK_OFF    = 3'd4;
  localparam logic [2:0] SW_RST_ASSERT = 3'd5;
  localparam logic [2:0] SW_RST_REL    = 3'd6;
  localparam logic [2:0] SW_CLK_ON     = 3'd7;
`endif

  logic [2:0]             state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [IDX_W-1:0]       dom_r, dom_s;
  logic [NUM_DOMAINS-1:0] arst_r, arst_s;
  logic [NUM_DOMAINS-1:0] clk_en_r, clk_en_s;
  logic                   done_r, done_s;

`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
  logic [NUM_DOMAINS-1:0] pending_r, pending_s;
  logic [NUM_DOMAINS-1:0] ack_r, ack_s;
  logic [IDX_W-1:0]       sel_s;

  // Lowest set bit wins; scanning downwards lets the last hit be the smallest index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_DOMAINS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = IDX_ZERO;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  assign sel_s        = lowest_idx(pending_r);
  assign sw_rst_ack_o = ack_r;
`else
  logic unused_sw_rst_req_s;
  assign unused_sw_rst_req_s = ^sw_rst_req_i;
  assign sw_rst_ack_o        = {NUM_DOMAINS{1'b0}};
`endif

  assign arst_no  = arst_r;
  assign clk_en_o = clk_en_r;
  assign done_o   = done_r;

  // Next-state, phase timer and next output values.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    dom_s    = dom_r;
    arst_s   = arst_r;
    clk_en_s = clk_en_r;
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
    ack_s     = {NUM_DOMAINS{1'b0}};
    pending_s = pending_r | sw_rst_req_i;
`endif
    if ((state_r != RUN) && (cnt_r != CNT_ZERO)) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = CNT_LOAD;
      case (state_r)
        BOOT_HOLD: begin
          state_s   = BOOT_RST_REL;
          dom_s     = IDX_ZERO;
          arst_s[0] = 1'b1;
        end
        BOOT_RST_REL: begin
          state_s         = BOOT_CLK_ON;
          clk_en_s[dom_r] = 1'b1;
        end
        BOOT_CLK_ON: begin
          if (dom_r == LAST_DOM) begin
            state_s = RUN;
          end else begin
            state_s       = BOOT_RST_REL;
            dom_s         = dom_r + IDX_ONE;
            arst_s[dom_s] = 1'b1;
          end
        end
        RUN: begin
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
          if (|pending_r) begin
            state_s          = SW_CLK_OFF;
            dom_s            = sel_s;
            clk_en_s[sel_s]  = 1'b0;
            // A fresh request in the same cycle must survive the clear.
            pending_s[sel_s] = sw_rst_req_i[sel_s];
          end else begin
            state_s = RUN;
          end
`else
          state_s = RUN;
`endif
        end
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
        SW_CLK_OFF: begin
          state_s       = SW_RST_ASSERT;
          arst_s[dom_r] = 1'b0;
        end
        SW_RST_ASSERT: begin
          state_s       = SW_RST_REL;
          arst_s[dom_r] = 1'b1;
        end
        SW_RST_REL: begin
          state_s         = SW_CLK_ON;
          clk_en_s[dom_r] = 1'b1;
        end
        SW_CLK_ON: begin
          state_s      = RUN;
          ack_s[dom_r] = 1'b1;
        end
`endif
        default: begin
          state_s  = BOOT_HOLD;
          dom_s    = IDX_ZERO;
          arst_s   = {NUM_DOMAINS{1'b0}};
          clk_en_s = {NUM_DOMAINS{1'b0}};
        end
      endcase
    end
    done_s = (state_s == RUN);
  end

  // State and registered outputs; glb_arst_ni forces everything back to the boot start.
  always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
    if (!glb_arst_ni) begin
      state_r   <= BOOT_HOLD;
      cnt_r     <= CNT_LOAD;
      dom_r     <= IDX_ZERO;
      arst_r    <= {NUM_DOMAINS{1'b0}};
      clk_en_r  <= {NUM_DOMAINS{1'b0}};
      done_r    <= 1'b0;
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
      pending_r <= {NUM_DOMAINS{1'b0}};
      ack_r     <= {NUM_DOMAINS{1'b0}};
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      dom_r     <= dom_s;
      arst_r    <= arst_s;
      clk_en_r  <= clk_en_s;
      done_r    <= done_s;
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
      pending_r <= pending_s;
      ack_r     <= ack_s;
`endif
    end
  end

endmodule

// File: tb/tb_soc_ctrl_rst_seq.sv
// Directed bench for soc_ctrl_rst_seq (NUM_DOMAINS=2, GAP_CYCLES=4) with a per-cycle expected-output queue.
// Expectations follow SOC_CTRL_RST_SEQ_SW_RST_EN: re-reset timelines when defined, steady RUN otherwise.
module tb_soc_ctrl_rst_seq;

  logic       ref_clk_i;
  logic       glb_arst_ni;
  logic [1:0] sw_rst_req_i;
  logic [1:0] sw_rst_ack_o;
  logic [1:0] arst_no;
  logic [1:0] clk_en_o;
  logic       done_o;

  int n_chk;
  int n_fail;

  // Packed as {arst_no, clk_en_o, sw_rst_ack_o, done_o}
  logic [6:0] exp_q[$];
  string      tag_q[$];

  soc_ctrl_rst_seq #(
    .NUM_DOMAINS(2),
    .GAP_CYCLES (4)
  ) dut (
    .ref_clk_i   (ref_clk_i),
    .glb_arst_ni (glb_arst_ni),
    .sw_rst_req_i(sw_rst_req_i),
    .sw_rst_ack_o(sw_rst_ack_o),
    .arst_no     (arst_no),
    .clk_en_o    (clk_en_o),
    .done_o      (done_o)
  );

  initial ref_clk_i = 1'b0;
  always #5 ref_clk_i = ~ref_clk_i;

  function automatic logic [6:0] observed();
    return {arst_no, clk_en_o, sw_rst_ack_o, done_o};
  endfunction

  task automatic push_n(input int n, input logic [6:0] v, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      tag_q.push_back(tag);
    end
  endtask

  task automatic push_idle(input int n);
    push_n(n, 7'b11_11_00_1, "run");
  endtask

  // Boot timeline: edges 1..20 after reset release, done_o from edge 20.
  task automatic push_boot();
    push_n(3, 7'b00_00_00_0, "boot_hold");
    push_n(4, 7'b01_00_00_0, "boot_rst0");
    push_n(4, 7'b01_01_00_0, "boot_clk0");
    push_n(4, 7'b11_01_00_0, "boot_rst1");
    push_n(4, 7'b11_11_00_0, "boot_clk1");
    push_n(1, 7'b11_11_00_1, "boot_done");
  endtask

  // First n cycles of one 17-cycle re-reset of domain d, counted from SW_CLK_OFF entry to the ack cycle.
  task automatic push_rr(input int d, input int n);
`ifdef SOC_CTRL_RST_SEQ_SW_RST_EN
    logic [1:0] m;
    logic [1:0] nm;
    m  = (d == 0) ? 2'b01 : 2'b10;
    nm = ~m;
    for (int i = 0; i < n; i++) begin
      if (i < 4)       push_n(1, {2'b11, nm, 2'b00, 1'b0}, "rr_clk_off");
      else if (i < 8)  push_n(1, {nm, nm, 2'b00, 1'b0}, "rr_rst_assert");
      else if (i < 12) push_n(1, {2'b11, nm, 2'b00, 1'b0}, "rr_rst_rel");
      else if (i < 16) push_n(1, {2'b11, 2'b11, 2'b00, 1'b0}, "rr_clk_on");
      else             push_n(1, {2'b11, 2'b11, m, 1'b1}, "rr_ack");
    end
`else
    if (d >= 0) push_idle(n);
    else push_idle(n);
`endif
  endtask

  task automatic check_now(input logic [6:0] e, input string tag);
    logic [6:0] o;
    o = observed();
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ref_clk_i);
      #1;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL underflow: observed %b expected <nothing queued>", observed());
      end else begin
        check_now(exp_q.pop_front(), tag_q.pop_front());
      end
    end
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) step(1);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    glb_arst_ni  = 1'b0;
    sw_rst_req_i = 2'b00;

    // Reset state
    repeat (3) @(posedge ref_clk_i);
    #1;
    check_now(7'b00_00_00_0, "reset_state");
    @(negedge ref_clk_i);
    glb_arst_ni = 1'b1;

    // Boot with a domain-0 request sampled at edge 6
    push_boot();
    push_rr(0, 17);
    push_idle(2);
    step(5);
    sw_rst_req_i = 2'b01;
    step(1);
    sw_rst_req_i = 2'b00;
    run_all();

    // Single request for domain 1
    sw_rst_req_i = 2'b10;
    push_idle(1);
    push_rr(1, 17);
    push_idle(2);
    step(1);
    sw_rst_req_i = 2'b00;
    run_all();

    // Simultaneous requests: domain 0 then domain 1, acks 17 cycles apart
    sw_rst_req_i = 2'b11;
    push_idle(1);
    push_rr(0, 17);
    push_rr(1, 17);
    push_idle(2);
    step(1);
    sw_rst_req_i = 2'b00;
    run_all();

    // Two re-requests during domain 0's own re-reset merge into one extra re-reset
    sw_rst_req_i = 2'b01;
    push_idle(1);
    push_rr(0, 17);
    push_rr(0, 17);
    push_idle(2);
    step(1);
    sw_rst_req_i = 2'b00;
    step(6);
    sw_rst_req_i = 2'b01;
    step(1);
    sw_rst_req_i = 2'b00;
    step(2);
    sw_rst_req_i = 2'b01;
    step(1);
    sw_rst_req_i = 2'b00;
    run_all();

    // Global reset while domain 1 is in SW_RST_REL, then a full re-boot
    sw_rst_req_i = 2'b10;
    push_idle(1);
    push_rr(1, 10);
    step(1);
    sw_rst_req_i = 2'b00;
    run_all();
    #2;
    glb_arst_ni = 1'b0;
    #1;
    check_now(7'b00_00_00_0, "async_reset");
    @(posedge ref_clk_i);
    #1;
    check_now(7'b00_00_00_0, "reset_held");
    @(negedge ref_clk_i);
    glb_arst_ni = 1'b1;
    push_boot();
    push_idle(3);
    run_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_ctrl_rst_seq.md
SOC_CTRL_RST_SEQ -- requirements
Module: soc_ctrl_rst_seq

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 2, giving the number of sequenced clock/reset domains (legal range 1..8).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16, giving the ref_clk_i cycles spent in every timed phase (legal minimum 1).
REQ-003 The block SHALL have port ref_clk_i, input, 1 bit: the only clock; all logic is in this domain.
REQ-004 The block SHALL have port glb_arst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port sw_rst_req_i, input, NUM_DOMAINS bits: single-cycle pulse per bit requesting a re-reset of that domain.
REQ-006 The block SHALL have port sw_rst_ack_o, output, NUM_DOMAINS bits: one-cycle pulse per bit when that domain's re-reset completes.
REQ-007 The block SHALL have port arst_no, output, NUM_DOMAINS bits: per-domain active-low reset, fed to each domain's arst_ni.
REQ-008 The block SHALL have port clk_en_o, output, NUM_DOMAINS bits: per-domain clock enable, fed to each domain's clk_en_i.
REQ-009 The block SHALL have port done_o, output, 1 bit: high when the boot sequence has finished and no re-reset is in progress.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-011 The FSM SHALL have the states BOOT_HOLD, BOOT_RST_REL, BOOT_CLK_ON, RUN, SW_CLK_OFF, SW_RST_ASSERT, SW_RST_REL and SW_CLK_ON.
REQ-012 Every state except RUN SHALL last exactly GAP_CYCLES cycles, timed by a down-counter of width $clog2(GAP_CYCLES+1) that is reloaded on every state entry.
REQ-013 Boot order: BOOT_HOLD -> BOOT_RST_REL(i) -> BOOT_CLK_ON(i) for i = 0..NUM_DOMAINS-1 in ascending order -> RUN.
REQ-014 arst_no[i] SHALL rise on entry to BOOT_RST_REL(i).
REQ-015 clk_en_o[i] SHALL rise on entry to BOOT_CLK_ON(i).
REQ-016 A domain's reset SHALL always be released before its clock is enabled, and its clock SHALL always be disabled before its reset is asserted.
REQ-017 done_o SHALL be high only in RUN.
REQ-018 Each sw_rst_req_i pulse SHALL set a sticky pending bit for that domain; pending bits SHALL be captured in every state.
REQ-019 In RUN with any pending bit set, the FSM SHALL select the lowest-index pending domain d, clear pending[d], and enter SW_CLK_OFF.
REQ-020 The re-reset sequence SHALL be: SW_CLK_OFF (clk_en_o[d]=0) -> SW_RST_ASSERT (arst_no[d]=0) -> SW_RST_REL (arst_no[d]=1) -> SW_CLK_ON (clk_en_o[d]=1) -> RUN.
REQ-021 sw_rst_ack_o[d] SHALL pulse for exactly one cycle on the transition from SW_CLK_ON to RUN.
REQ-022 Other domains SHALL be unaffected during a re-reset.
REQ-023 A request for d arriving during d's own re-reset SHALL re-set pending[d], causing one more full re-reset afterwards.
REQ-024 Requests for a domain that is already pending SHALL merge into a single re-reset.
REQ-025 Requests arriving during boot SHALL be held and serviced after RUN is reached.
REQ-026 Simultaneous requests SHALL be serviced one at a time in ascending index order, with RUN held for exactly one cycle between services.

Reset
REQ-027 Assertion of glb_arst_ni SHALL immediately force arst_no=0, clk_en_o=0, sw_rst_ack_o=0, done_o=0, pending=0 and state BOOT_HOLD, including when it occurs mid-sequence.
REQ-028 After deassertion of glb_arst_ni, the full boot sequence SHALL restart from BOOT_HOLD.

Configuration
REQ-029 Macro SOC_CTRL_RST_SEQ_SW_RST_EN SHALL control the software re-reset path.
REQ-030 With SOC_CTRL_RST_SEQ_SW_RST_EN defined, the pending register and the SW_* states SHALL be implemented as specified above.
REQ-031 Without SOC_CTRL_RST_SEQ_SW_RST_EN, sw_rst_req_i SHALL be ignored, sw_rst_ack_o SHALL be tied to 0, the SW_* states and pending logic SHALL be absent, and the FSM SHALL remain in RUN after boot.

Verification (NUM_DOMAINS=2, GAP_CYCLES=4; edge 1 is the first ref_clk_i rising edge after glb_arst_ni deasserts)
REQ-032 Boot: glb_arst_ni deasserted -> arst_no[0] rises after edge 4, clk_en_o[0] after edge 8, arst_no[1] after edge 12, clk_en_o[1] after edge 16, done_o after edge 20.
REQ-033 Single request: pulse sw_rst_req_i=2'b10 in RUN -> clk_en_o[1] falls, then 4 cycles later arst_no[1] falls, 4 cycles later arst_no[1] rises, 4 cycles later clk_en_o[1] rises, 4 cycles later sw_rst_ack_o=2'b10 for one cycle; domain 0 outputs stay at 1 throughout.
REQ-034 Simultaneous requests: sw_rst_req_i=2'b11 in one cycle -> domain 0 is fully re-reset and acked first, then domain 1; two ack pulses 17 cycles apart.
REQ-035 Request during boot: sw_rst_req_i=2'b01 at edge 6 -> boot completes unchanged, then domain 0 is re-reset once.
REQ-036 Mid-sequence reset: glb_arst_ni asserted during SW_RST_REL -> all outputs are 0 immediately; after release, the boot timeline of REQ-032 repeats exactly.
REQ-037 Macro off: build without SOC_CTRL_RST_SEQ_SW_RST_EN and pulse sw_rst_req_i=2'b11 -> outputs stay constant at all 1s and sw_rst_ack_o stays 0.
